fifo_ram_ctrl: RTL and testbench
================================

Name: fifo_ram_ctrl

Overview:
Synchronous FIFO controller that drives an external dual-port RAM.
- RAM write port: synchronous write, strobed.
- RAM read port: combinational, address in, data out.
- Converts the RAM into a valid/ready streaming FIFO with a registered output stage.
- Sits between a producer stream and a consumer stream; the RAM is instantiated beside it at the integration level.

Parameters:
WIDTH, 8, data word width in bits
DEPTH_LOG, 8, log2 of RAM entries; RAM holds 2**DEPTH_LOG words

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
din_valid  in  1  producer has a word
din_ready  out  1  controller can accept a word
din_data  in  WIDTH  producer word
dout_valid  out  1  output register holds a word
dout_ready  in  1  consumer takes the word
dout_data  out  WIDTH  head-of-FIFO word, registered
ram_write_req  out  1  RAM write strobe
ram_write_addr  out  DEPTH_LOG  RAM write address
ram_write_data  out  WIDTH  RAM write data
ram_read_addr  out  DEPTH_LOG  RAM read address
ram_read_data  in  WIDTH  combinational RAM read data
level  out  DEPTH_LOG+1  words currently held in RAM; excludes the output register
full  out  1  RAM full
empty  out  1  RAM empty; the output register may still be valid

Behaviour:
Pointers
- wptr and rptr are DEPTH_LOG+1 bits each: the low bits are the address, the MSB is the wrap bit.
- empty = (wptr == rptr).
- full = low bits equal and MSBs differ.
- level = wptr - rptr, modulo 2**(DEPTH_LOG+1).

Push side
- din_ready = ~full. Combinational from registered pointers only; it never depends on same-cycle pops.
- push = din_valid & din_ready.
- ram_write_req = push; ram_write_addr = wptr[DEPTH_LOG-1:0]; ram_write_data = din_data.
- wptr increments on push. Wrap of the low bits is natural; the MSB toggles.
- din_valid while full is ignored: no write, no pointer change, no overflow.

Pop side
- ram_read_addr = rptr[DEPTH_LOG-1:0] at all times.
- load = ~empty & (~dout_valid | dout_ready).
- On load: dout_data <= ram_read_data, dout_valid <= 1, rptr increments.
- If dout_valid & dout_ready & ~load: dout_valid <= 0; dout_data holds its value.
- dout_data and dout_valid are stable while dout_valid & ~dout_ready.

Latency and capacity
- Latency: a word pushed at edge N becomes RAM-visible after N. It is loaded at edge N+1 and dout_valid is high from cycle N+2. First-word latency is 2 cycles; no bypass path.
- Throughput: 1 word/cycle sustained on both sides.
- Total capacity: 2**DEPTH_LOG + 1 words (RAM plus output register).

Simultaneous events
- Push and load in the same cycle: both pointers advance and level is unchanged.
- Push while empty: no load that cycle, because load uses pre-edge empty.
- Full with a consumer pop: the load frees one RAM slot. din_ready rises in the next cycle, not the same one.
- Wrap-around: pointer MSBs toggle on every 2**DEPTH_LOG-th increment. Full/empty must stay correct across repeated wraps.

Reset
- rst asserted at any time, including mid-transfer: wptr = rptr = 0, dout_valid = 0, dout_data = 0. All in-flight and stored words are discarded.
- Resulting outputs: level = 0, empty = 1, full = 0, din_ready = 1, ram_write_req = 0, ram_read_addr = 0.
- RAM contents are not cleared; they are unreachable after reset.

Decomposition:
- Shared package fifo_pkg holds the pointer-width constant (PTR_W = DEPTH_LOG+1) and a pointer compare helper for full/empty. It is reused by future async/gray-code FIFOs.
- One natural sub-module: fifo_out_stage. It holds the output register and the load/valid logic, and takes ram_read_data, empty, and dout_ready as inputs.
- Pointer logic stays in fifo_ram_ctrl.

Test Plan:
WIDTH=8, DEPTH_LOG=2 throughout.
1. Reset then idle -> empty=1, full=0, level=0, din_ready=1, dout_valid=0, ram_write_req=0.
2. Single push 0xA5 at edge N, dout_ready=1 -> ram_write_req=1 with addr 0 in cycle N. dout_valid=1 and dout_data=0xA5 in cycle N+2. Popped at the next edge, then dout_valid=0.
3. dout_ready=0, push 0x01..0x06 -> 0x01 sits in the output register. 0x02..0x05 fill the RAM: level=4, full=1, din_ready=0. 0x06 is not written (ram_write_req=0). Then dout_ready=1 -> outputs 0x01..0x05 in order.
4. Continuous push and pop of 0x00..0x13 with both sides always ready -> 20 words out in order. Exactly one output per cycle after the 2-cycle fill. Pointers wrap 5 times; full never asserted.
5. Full FIFO with one pop -> din_ready=1 one cycle after the pop edge. A push in that cycle lands at the freed address; level returns to 4.
6. Assert rst while level=3 and dout_valid=1 -> all outputs go to reset values immediately (async). After release, push 0x7E -> 0x7E is the next word out, and no stale data appears.

Source files
------------

// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
//   Shared FIFO helpers: pointer-width derivation and wrap-bit pointer
//   compares. Binary-pointer FIFOs use these directly; gray-code and async
//   variants can reuse the same full/empty rule after converting pointers.
//
//   Pointers are passed zero-extended to ptr_word_t so a single helper serves
//   every depth. A pointer for a 2**addr_w entry store is addr_w+1 bits wide:
//   the low addr_w bits address the store and bit addr_w is the wrap bit.
// ----------------------------------------------------------------------------
package fifo_pkg;

    localparam int unsigned MAX_PTR_W = 32;

    typedef logic [MAX_PTR_W-1:0] ptr_word_t;

    // Output register occupancy for the registered read stage.
    typedef enum logic {
        StEmpty,
        StHold
    } out_state_e;

    // Pointer width for a store of 2**depth_log entries (address + wrap bit).
    function automatic int unsigned ptr_width(input int unsigned depth_log);
        return depth_log + 1;
    endfunction

    // Same address and same lap: nothing stored.
    function automatic logic ptr_empty(input ptr_word_t wptr, input ptr_word_t rptr);
        return wptr == rptr;
    endfunction

    // Same address but the writer is one lap ahead: every entry is occupied.
    function automatic logic ptr_full(input ptr_word_t wptr, input ptr_word_t rptr,
                                      input int unsigned addr_w);
        ptr_word_t diff;
        ptr_word_t low_mask;
        diff     = wptr ^ rptr;
        low_mask = (ptr_word_t'(1) << addr_w) - ptr_word_t'(1);
        return ((diff & low_mask) == '0) && diff[addr_w];
    endfunction

endpackage

// File: rtl/fifo_ram_ctrl_if.sv
// ----------------------------------------------------------------------------
// fifo_ram_ctrl_if
//   Bundles the producer stream, consumer stream, external RAM ports and the
//   status outputs of fifo_ram_ctrl.
//
//   master : controller view (drives din_ready, dout_*, ram_write_*,
//            ram_read_addr, level, full, empty)
//   slave  : environment view (drives din_valid, din_data, dout_ready,
//            ram_read_data)
// ----------------------------------------------------------------------------
interface fifo_ram_ctrl_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH_LOG = 8
);

    // Producer stream
    logic                 din_valid;
    logic                 din_ready;
    logic [WIDTH-1:0]     din_data;

    // Consumer stream
    logic                 dout_valid;
    logic                 dout_ready;
    logic [WIDTH-1:0]     dout_data;

    // External dual-port RAM
    logic                 ram_write_req;
    logic [DEPTH_LOG-1:0] ram_write_addr;
    logic [WIDTH-1:0]     ram_write_data;
    logic [DEPTH_LOG-1:0] ram_read_addr;
    logic [WIDTH-1:0]     ram_read_data;

    // Status
    logic [DEPTH_LOG:0]   level;
    logic                 full;
    logic                 empty;

    modport master (
        input  din_valid,
        input  din_data,
        input  dout_ready,
        input  ram_read_data,
        output din_ready,
        output dout_valid,
        output dout_data,
        output ram_write_req,
        output ram_write_addr,
        output ram_write_data,
        output ram_read_addr,
        output level,
        output full,
        output empty
    );

    modport slave (
        output din_valid,
        output din_data,
        output dout_ready,
        output ram_read_data,
        input  din_ready,
        input  dout_valid,
        input  dout_data,
        input  ram_write_req,
        input  ram_write_addr,
        input  ram_write_data,
        input  ram_read_addr,
        input  level,
        input  full,
        input  empty
    );

endinterface

// File: rtl/fifo_out_stage.sv
// ----------------------------------------------------------------------------
// fifo_out_stage
//   Registered output stage of the RAM FIFO. Whenever the RAM holds a word and
//   the output register is free (or being emptied this cycle) the head word is
//   captured from the combinational RAM read port and load_o tells the
//   controller to advance its read pointer.
//
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     empty_i           RAM holds no words (registered pointers)
//     dout_ready_i      consumer accepts the output word
//     ram_read_data_i   RAM word at the current read address
//     load_o            head word captured at the next edge
//     dout_valid_o      output register holds a word
//     dout_data_o       output register contents
// ----------------------------------------------------------------------------
module fifo_out_stage
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             empty_i,
    input  logic             dout_ready_i,
    input  logic [WIDTH-1:0] ram_read_data_i,
    output logic             load_o,
    output logic             dout_valid_o,
    output logic [WIDTH-1:0] dout_data_o
);

    out_state_e       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             load;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        load    = 1'b0;
        unique case (state_q)
            StEmpty: begin
                if (!empty_i) begin
                    load    = 1'b1;
                    data_d  = ram_read_data_i;
                    state_d = StHold;
                end
            end
            StHold: begin
                // Data only moves when the consumer takes the current word,
                // which keeps dout stable under backpressure.
                if (dout_ready_i) begin
                    if (!empty_i) begin
                        load   = 1'b1;
                        data_d = ram_read_data_i;
                    end else begin
                        state_d = StEmpty;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign load_o       = load;
    assign dout_valid_o = (state_q == StHold);
    assign dout_data_o  = data_q;

endmodule

// File: rtl/fifo_ram_ctrl.sv
// ----------------------------------------------------------------------------
// fifo_ram_ctrl
//   Turns an external dual-port RAM (synchronous strobed write, combinational
//   read) into a valid/ready streaming FIFO with a registered output word.
//   Capacity is 2**DEPTH_LOG words in RAM plus one in the output register.
//
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     bus        fifo_ram_ctrl_if.master:
//                  din_valid/din_ready/din_data     producer stream
//                  dout_valid/dout_ready/dout_data  consumer stream
//                  ram_write_req/addr/data          RAM write port
//                  ram_read_addr/ram_read_data      RAM read port
//                  level/full/empty                 RAM occupancy only
// ----------------------------------------------------------------------------
module fifo_ram_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH_LOG = 8
) (
    input  logic            clk,
    input  logic            rst,
    fifo_ram_ctrl_if.master bus
);

    localparam int unsigned PTR_W = ptr_width(DEPTH_LOG);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic             full;
    logic             empty;
    logic             push;
    logic             load;

    // Status from registered pointers only, so din_ready never depends on a
    // pop happening in the same cycle.
    always_comb begin
        full  = ptr_full(ptr_word_t'(wptr_q), ptr_word_t'(rptr_q), DEPTH_LOG);
        empty = ptr_empty(ptr_word_t'(wptr_q), ptr_word_t'(rptr_q));
    end

    assign push = bus.din_valid & ~full;

    // Pointers wrap naturally; the MSB toggles once per lap.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (load) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    fifo_out_stage #(
        .WIDTH (WIDTH)
    ) u_out_stage (
        .clk             (clk),
        .rst             (rst),
        .empty_i         (empty),
        .dout_ready_i    (bus.dout_ready),
        .ram_read_data_i (bus.ram_read_data),
        .load_o          (load),
        .dout_valid_o    (bus.dout_valid),
        .dout_data_o     (bus.dout_data)
    );

    assign bus.din_ready      = ~full;
    assign bus.ram_write_req  = push;
    assign bus.ram_write_addr = wptr_q[DEPTH_LOG-1:0];
    assign bus.ram_write_data = bus.din_data;
    assign bus.ram_read_addr  = rptr_q[DEPTH_LOG-1:0];
    // Modulo 2**PTR_W difference counts RAM words only, not the output word.
    assign bus.level          = wptr_q - rptr_q;
    assign bus.full           = full;
    assign bus.empty          = empty;

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
module tb_fifo_ram_ctrl;

    localparam int unsigned W      = 8;
    localparam int unsigned DL     = 2;
    localparam int unsigned NWORDS = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fifo_ram_ctrl_if #(.WIDTH(W), .DEPTH_LOG(DL)) bus ();

    fifo_ram_ctrl #(
        .WIDTH     (W),
        .DEPTH_LOG (DL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External RAM beside the controller
    logic [W-1:0] mem [NWORDS];

    always @(posedge clk) begin
        if (bus.ram_write_req) mem[bus.ram_write_addr] <= bus.ram_write_data;
    end

    assign bus.ram_read_data = mem[bus.ram_read_addr];

    int errors = 0;
    int checks = 0;

    // Reference model: words in RAM as a queue, plus the output register.
    logic [W-1:0] ram_m [$];
    bit           ov_m;
    logic [W-1:0] od_m;
    int unsigned  wcnt_m;
    int unsigned  rcnt_m;

    // Scoreboard: every accepted word in acceptance order.
    logic [W-1:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ram_m.delete();
        exp_q.delete();
        ov_m   = 1'b0;
        od_m   = '0;
        wcnt_m = 0;
        rcnt_m = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_level"},     32'(bus.level),         32'd0);
        chk({tag, "_empty"},     32'(bus.empty),         32'd1);
        chk({tag, "_full"},      32'(bus.full),          32'd0);
        chk({tag, "_din_ready"}, 32'(bus.din_ready),     32'd1);
        chk({tag, "_dout_valid"},32'(bus.dout_valid),    32'd0);
        chk({tag, "_dout_data"}, 32'(bus.dout_data),     32'd0);
        chk({tag, "_wr_req"},    32'(bus.ram_write_req), 32'd0);
        chk({tag, "_rd_addr"},   32'(bus.ram_read_addr), 32'd0);
    endtask

    // Compare current outputs against the model, then advance the model by
    // the edge that follows using the inputs now applied.
    task automatic check_and_advance();
        int unsigned n;
        bit push_m;
        bit load_m;
        n = ram_m.size();
        chk("empty",      32'(bus.empty),         32'(n == 0));
        chk("full",       32'(bus.full),          32'(n == NWORDS));
        chk("level",      32'(bus.level),         n);
        chk("din_ready",  32'(bus.din_ready),     32'(n < NWORDS));
        chk("dout_valid", 32'(bus.dout_valid),    32'(ov_m));
        chk("dout_data",  32'(bus.dout_data),     32'(od_m));
        chk("rd_addr",    32'(bus.ram_read_addr), rcnt_m % NWORDS);
        push_m = bus.din_valid && (n < NWORDS);
        load_m = (n > 0) && (!ov_m || bus.dout_ready);
        chk("wr_req", 32'(bus.ram_write_req), 32'(push_m));
        if (push_m) begin
            chk("wr_addr", 32'(bus.ram_write_addr), wcnt_m % NWORDS);
            chk("wr_data", 32'(bus.ram_write_data), 32'(bus.din_data));
            exp_q.push_back(bus.din_data);
        end
        if (load_m) begin
            od_m = ram_m.pop_front();
            ov_m = 1'b1;
            rcnt_m++;
        end else if (ov_m && bus.dout_ready) begin
            ov_m = 1'b0;
        end
        if (push_m) begin
            ram_m.push_back(bus.din_data);
            wcnt_m++;
        end
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic step(input bit dv, input logic [W-1:0] dd, input bit dr);
        bus.din_valid  = dv;
        bus.din_data   = dd;
        bus.dout_ready = dr;
        @(negedge clk);
        check_and_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, '0, 1'b1);
    endtask

    // Monitor: a handshake seen now completes at the next edge.
    always @(negedge clk) begin
        if (!rst && bus.dout_valid && bus.dout_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %0h expected none at %0t",
                         bus.dout_data, $time);
            end else begin
                chk("sb_dout", 32'(bus.dout_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        bus.din_valid  = 1'b0;
        bus.din_data   = '0;
        bus.dout_ready = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        check_reset_outputs("rst_init");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1. idle
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);

        // 2. single word, 2-cycle latency
        step(1'b1, 8'hA5, 1'b1);
        drain(4);

        // 3. backpressure fill; the sixth word is refused
        for (int i = 1; i <= 6; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b0, '0, 1'b0);
        drain(7);

        // 4. streaming with both sides ready, several pointer wraps
        for (int i = 0; i < 20; i++) step(1'b1, 8'(i), 1'b1);
        drain(4);

        // 5. full, one pop, then a push into the freed slot
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
        step(1'b1, 8'hEE, 1'b1);
        step(1'b1, 8'h55, 1'b0);
        step(1'b0, '0, 1'b0);
        drain(7);

        // 6. asynchronous reset with words in flight
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_outputs("rst_async");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 8'h7E, 1'b1);
        drain(4);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom),
                 1'($urandom_range(0, 2) != 0));
        end
        drain(8);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
